// File: rtl/fetch_stage.sv
// Fetch stage: holds the fetch PC and drives the instruction-memory address.
// It selects the next PC (sequential, branch, jump, register jump, eret or
// exception entry), flags fetch address errors, and counts advanced fetches.
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_LO     = 32'h0000_3000,
  parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        stall,
  input  logic        eret_D,
  input  logic [31:0] EPC,
  input  logic [2:0]  npc_op_D,
  input  logic        br_cond_D,
  input  logic [31:0] pc_D,
  input  logic [15:0] Imm16_D,
  input  logic [25:0] Imm26_D,
  input  logic [31:0] rs_fwd_D,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] Instr_F,
  output logic [31:0] pc_F,
  output logic        ISDB_F,
  output logic [4:0]  EXCode_F,
  output logic [31:0] fetch_cnt
);

  localparam logic [2:0] NpcSeq    = 3'd0;
  localparam logic [2:0] NpcBranch = 3'd1;
  localparam logic [2:0] NpcJump   = 3'd2;
  localparam logic [2:0] NpcJreg   = 3'd3;

  localparam logic [4:0] ExcNone = 5'd0;
  localparam logic [4:0] ExcAdEL = 5'd4;

  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_seq;
  logic [31:0] br_target;
  logic [31:0] npc;
  logic        adel;

  assign pc_seq    = pc_q + 32'd4;
  assign br_target = pc_D + 32'd4 + {{14{Imm16_D[15]}}, Imm16_D, 2'b00};

  // Redirect target chosen by the instruction in D; unknown ops fall through.
  always_comb begin
    npc = pc_seq;
    case (npc_op_D)
      NpcBranch: npc = br_cond_D ? br_target : pc_seq;
      NpcJump:   npc = {pc_D[31:28], Imm26_D, 2'b00};
      NpcJreg:   npc = rs_fwd_D;
      default:   npc = pc_seq;
    endcase
  end

  // PC priority: exception entry, then stall hold, then eret, then NPC.
  // The counter advances only when the PC moves under program control.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (Req) begin
      pc_d = EXC_ENTRY;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (eret_D) begin
      pc_d  = EPC;
      cnt_d = cnt_q + 32'd1;
    end else begin
      pc_d  = npc;
      cnt_d = cnt_q + 32'd1;
    end
  end

  // PC and fetch counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= PC_RESET;
      cnt_q <= 32'd0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  // Fetch address error: misaligned or outside the instruction memory window.
  always_comb begin
    adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
  end

  // Outputs; a faulting fetch delivers a nop so D never decodes garbage.
  always_comb begin
    i_inst_addr = pc_q;
    pc_F        = pc_q;
    fetch_cnt   = cnt_q;
    Instr_F     = adel ? 32'd0 : i_inst_rdata;
    EXCode_F    = adel ? ExcAdEL : ExcNone;
    // Any control-transfer in D makes F its delay slot, taken or not; eret has none.
    ISDB_F      = ((npc_op_D == NpcBranch) || (npc_op_D == NpcJump) ||
                   (npc_op_D == NpcJreg)) && !eret_D;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver pushes expected outputs from a
// behavioural PC model; a negedge monitor pops and compares.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, Req, stall, eret_D, br_cond_D;
  logic [31:0] EPC, pc_D, rs_fwd_D, i_inst_rdata;
  logic [2:0]  npc_op_D;
  logic [15:0] Imm16_D;
  logic [25:0] Imm26_D;
  logic [31:0] i_inst_addr, Instr_F, pc_F, fetch_cnt;
  logic        ISDB_F;
  logic [4:0]  EXCode_F;

  fetch_stage dut (
    .clk(clk), .reset(reset), .Req(Req), .stall(stall), .eret_D(eret_D), .EPC(EPC),
    .npc_op_D(npc_op_D), .br_cond_D(br_cond_D), .pc_D(pc_D), .Imm16_D(Imm16_D),
    .Imm26_D(Imm26_D), .rs_fwd_D(rs_fwd_D), .i_inst_addr(i_inst_addr),
    .i_inst_rdata(i_inst_rdata), .Instr_F(Instr_F), .pc_F(pc_F), .ISDB_F(ISDB_F),
    .EXCode_F(EXCode_F), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        isdb;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: the PC and counter the spec says F should hold now.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
  endtask

  function automatic bit bad_fetch(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  // Monitor: outputs are valid every cycle once a step has been issued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc_F", pc_F, e.pc);
      chk("i_inst_addr", i_inst_addr, e.pc);
      chk("Instr_F", Instr_F, e.instr);
      chk("EXCode_F", {27'd0, EXCode_F}, {27'd0, e.exc});
      chk("ISDB_F", {31'd0, ISDB_F}, {31'd0, e.isdb});
      chk("fetch_cnt", fetch_cnt, e.cnt);
    end
  end

  // One cycle: drive D-side inputs, predict F outputs, then advance the model.
  task automatic step(input logic rst, input logic req, input logic stl, input logic ert,
                      input logic [31:0] epc, input logic [2:0] op, input logic br,
                      input logic [31:0] pcd, input logic [15:0] i16,
                      input logic [25:0] i26, input logic [31:0] rs);
    exp_t e;
    logic [31:0] target;
    reset = rst; Req = req; stall = stl; eret_D = ert; EPC = epc; npc_op_D = op;
    br_cond_D = br; pc_D = pcd; Imm16_D = i16; Imm26_D = i26; rs_fwd_D = rs;
    i_inst_rdata = $urandom;
    e.pc    = m_pc;
    e.cnt   = m_cnt;
    e.exc   = bad_fetch(m_pc) ? 5'd4 : 5'd0;
    e.instr = bad_fetch(m_pc) ? 32'd0 : i_inst_rdata;
    e.isdb  = (op >= 3'd1 && op <= 3'd3) && !ert;
    exp_q.push_back(e);
    // Where the program would go next if nothing intervenes.
    if (op == 3'd1 && br)  target = pcd + 32'd4 + 32'($signed(i16)) * 32'd4;
    else if (op == 3'd2)   target = (pcd & 32'hF000_0000) | (32'(i26) * 32'd4);
    else if (op == 3'd3)   target = rs;
    else                   target = m_pc + 32'd4;
    @(posedge clk);
    if (rst)       begin m_pc = 32'h3000; m_cnt = 0; end
    else if (req)  m_pc = 32'h4180;
    else if (stl)  ;
    else if (ert)  begin m_pc = epc;    m_cnt = m_cnt + 1; end
    else           begin m_pc = target; m_cnt = m_cnt + 1; end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 3'd0, 0, 32'h3000, 16'h0, 26'h0, 32'h0);
  endtask

  initial begin
    reset = 1; Req = 0; stall = 0; eret_D = 0; EPC = 0; npc_op_D = 0; br_cond_D = 0;
    pc_D = 0; Imm16_D = 0; Imm26_D = 0; rs_fwd_D = 0; i_inst_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    m_pc = 32'h3000; m_cnt = 0;
    reset = 0;

    // Reset and sequential fetch.
    chk("reset pc", pc_F, 32'h3000);
    chk("reset cnt", fetch_cnt, 32'd0);
    idle(); chk("seq pc1", pc_F, 32'h3004);
    idle(); chk("seq pc2", pc_F, 32'h3008);
    idle(); chk("seq pc3", pc_F, 32'h300C);
    chk("seq cnt3", fetch_cnt, 32'd3);

    // Backward beq taken, then not taken.
    step(0, 0, 0, 0, 0, 3'd1, 1, 32'h3010, 16'hFFFC, 26'h0, 32'h0);
    chk("beq taken", pc_F, 32'h3004);
    step(0, 0, 0, 0, 0, 3'd1, 0, 32'h3010, 16'hFFFC, 26'h0, 32'h0);
    chk("beq not taken", pc_F, 32'h3008);

    // jr to misaligned and out-of-range targets.
    step(0, 0, 0, 0, 0, 3'd3, 0, 32'h3004, 16'h0, 26'h0, 32'h3002);
    chk("jr misaligned pc", pc_F, 32'h3002);
    chk("jr misaligned exc", {27'd0, EXCode_F}, 32'd4);
    chk("jr misaligned instr", Instr_F, 32'd0);
    step(0, 0, 0, 0, 0, 3'd3, 0, 32'h3004, 16'h0, 26'h0, 32'h7000);
    chk("jr high exc", {27'd0, EXCode_F}, 32'd4);
    step(0, 0, 0, 0, 0, 3'd3, 0, 32'h3004, 16'h0, 26'h0, 32'h3000);

    // Stalled jump holds PC and counter, then resolves on release.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 3'd2, 0, 32'h3000, 16'h0, 26'hC40, 32'h0);
    chk("stall pc", pc_F, 32'h3000);
    chk("stall cnt", fetch_cnt, 32'd8);
    step(0, 0, 0, 0, 0, 3'd2, 0, 32'h3000, 16'h0, 26'hC40, 32'h0);
    chk("jump target", pc_F, 32'h3100);

    // Req beats stall and eret; eret alone goes to EPC.
    step(0, 1, 1, 1, 32'h3020, 3'd0, 0, 32'h3000, 16'h0, 26'h0, 32'h0);
    chk("req entry", pc_F, 32'h4180);
    step(0, 0, 0, 1, 32'h3020, 3'd2, 0, 32'h3000, 16'h0, 26'h0, 32'h0);
    chk("eret pc", pc_F, 32'h3020);

    // Reset during a taken branch.
    step(1, 0, 0, 0, 0, 3'd1, 1, 32'h3010, 16'h0040, 26'h0, 32'h0);
    chk("reset mid branch pc", pc_F, 32'h3000);
    chk("reset mid branch cnt", fetch_cnt, 32'd0);

    // Random traffic, biased toward legal targets with occasional faults.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pcd, rs, epc;
      logic [25:0] i26;
      pcd = 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
      rs  = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
      epc = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
      i26 = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'($urandom_range(32'hC00, 32'h1BFF));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, epc, 3'($urandom_range(0, 7)), 1'($urandom),
           pcd, 16'($signed(10'($urandom))), i26, rs);
    end

    // Let the monitor drain the last entry.
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
